param_rsrv_station: RTL and testbench
=====================================

PARAM_RSRV_STATION -- requirements
Module: param_rsrv_station

Interface
REQ-001 SHALL have parameter RS_DEPTH, default 16, meaning entry count (power of 2, 4..64).
REQ-002 SHALL have parameter CDB_PORTS, default 2, meaning broadcast result buses snooped.
REQ-003 SHALL have parameter ROB_ID_W, default 5, meaning tag width; tag 0 means "operand ready".
REQ-004 SHALL have parameters DATA_W, default 32, and OPTYPE_W, default 6, meaning the data and opcode widths.
REQ-005 SHALL have ports: clk in 1 clock; rst_n in 1 reset (one clock; reset is synchronous and active-low).
REQ-006 SHALL have ports: rdy in 1 global run enable; rollback in 1 flush.
REQ-007 SHALL have dispatch ports: disp_valid in 1; disp_op in OPTYPE_W; disp_pc in DATA_W; disp_id in ROB_ID_W; disp_qi/disp_qj in ROB_ID_W; disp_vi/disp_vj/disp_imm in DATA_W.
REQ-008 SHALL have status ports: rs_full out 1; rs_count out clog2(RS_DEPTH)+1, meaning occupancy.
REQ-009 SHALL have issue ports: out_valid out 1; out_ready in 1; out_op, out_id, out_pc, out_vi, out_vj, out_imm out (widths as dispatch).
REQ-010 SHALL have CDB ports: cdb_valid in CDB_PORTS; cdb_tag in CDB_PORTS*ROB_ID_W; cdb_data in CDB_PORTS*DATA_W (port p at slice p).

Function
REQ-011 SHALL accept a dispatch when rdy && disp_valid && !rs_full, writing the lowest-index free entry.
REQ-012 SHALL derive rs_full and rs_count from registered busy bits only; an entry freed by issue in cycle t is not reusable until t+1.
REQ-013 SHALL bypass CDB at dispatch: if any valid port tag equals nonzero disp_qi/qj, store tag 0 and that port's data.
REQ-014 SHALL wake up every busy entry whose nonzero Qi/Qj matches a valid CDB tag: set Q to 0 and V to the data, all ports in the same cycle.
REQ-015 SHALL resolve duplicate tag matches across ports to the lowest port index, and SHALL ignore CDB tag 0.
REQ-016 SHALL select a ready entry (busy, Qi==0, Qj==0) when rdy && (!out_valid || out_ready), load the output register, and clear that entry's busy bit.
REQ-017 SHALL hold out_* stable while out_valid && !out_ready, and SHALL drop out_valid when accepted with no ready entry.
REQ-018 SHALL give a ready-at-dispatch entry an issue latency of 2 edges (stored at edge 1, out_valid at edge 2).
REQ-019 SHALL, while rdy is low, hold all state and outputs and ignore dispatch and CDB.
REQ-020 SHALL, on rollback (rdy-independent), clear all busy bits, the age state, and out_valid on the next edge, and ignore same-cycle dispatch.

Reset
REQ-021 SHALL, on rst_n low at an edge, clear busy, age matrix, Qi/Qj to 0, out_valid to 0, rs_count to 0, and rs_full to 0; out_* data SHALL be 0.
REQ-022 SHALL give reset priority over rollback, and rollback priority over all other activity.

Configuration
REQ-023 SHALL support macro RS_AGE_SELECT_EN: defined selects oldest ready entry via an RS_DEPTH x RS_DEPTH age matrix updated on dispatch; undefined selects the lowest-index ready entry with no age storage.

Structure
REQ-024 SHALL keep REG_ZERO/tag-zero constant, NOP opcode, and default widths in the shared constants package.
REQ-025 SHALL place selection in one sub-module, rs_pick_oldest (ready vector + age matrix in, one-hot grant + any out).

Verification
REQ-026 SHALL check: dispatch id=3 qi=qj=0 into empty RS -> out_valid at edge 2, out_id=3, rs_count 1 then 0.
REQ-027 SHALL check: dispatch id=4 qi=7, then CDB port1 tag7 data=0x55 -> out_vi=0x55 one edge after the broadcast.
REQ-028 SHALL check: fill RS_DEPTH entries all qi=9 -> rs_full=1 and an extra dispatch is dropped; broadcast tag9 -> entries issue in dispatch order (with RS_AGE_SELECT_EN).
REQ-029 SHALL check: out_ready held low 5 cycles with out_valid=1 -> out_* unchanged and no entry freed.
REQ-030 SHALL check: rollback with 6 busy entries and out_valid=1 -> rs_count=0 and out_valid=0 next edge; rst_n low mid-run -> all REQ-021 values.
REQ-031 SHALL check: dispatch qi=5 while CDB port0 tag5 data=0xA0 same cycle -> entry issues with vi=0xA0.

Source files
------------

// File: rtl/param_rsrv_station_pkg.sv
// Shared constants for the reservation station: default widths, ready tag, NOP opcode.
// Latency: none (constants only).
// Backpressure: n/a.
package param_rsrv_station_pkg;

    localparam int DEF_RS_DEPTH  = 16;
    localparam int DEF_CDB_PORTS = 2;
    localparam int DEF_ROB_ID_W  = 5;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_OPTYPE_W  = 6;

    // A source tag of zero means the operand value is already present.
    localparam int REG_ZERO = 0;

    // Opcode presented on the issue port when nothing has been issued yet.
    localparam int OP_NOP = 0;

endpackage

// File: rtl/param_rsrv_station_if.sv
// Dispatch, issue and CDB bundle between the reservation station and its neighbours.
// Latency: none (wires only).
// Backpressure: issue side is valid/ready; dispatch and CDB are fire-and-forget.
interface param_rsrv_station_if
    import param_rsrv_station_pkg::*;
#(
    parameter int CDB_PORTS = DEF_CDB_PORTS,
    parameter int ROB_ID_W  = DEF_ROB_ID_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int OPTYPE_W  = DEF_OPTYPE_W
);
    logic                          disp_valid;
    logic [OPTYPE_W-1:0]           disp_op;
    logic [DATA_W-1:0]             disp_pc;
    logic [ROB_ID_W-1:0]           disp_id;
    logic [ROB_ID_W-1:0]           disp_qi;
    logic [ROB_ID_W-1:0]           disp_qj;
    logic [DATA_W-1:0]             disp_vi;
    logic [DATA_W-1:0]             disp_vj;
    logic [DATA_W-1:0]             disp_imm;

    logic                          out_valid;
    logic                          out_ready;
    logic [OPTYPE_W-1:0]           out_op;
    logic [ROB_ID_W-1:0]           out_id;
    logic [DATA_W-1:0]             out_pc;
    logic [DATA_W-1:0]             out_vi;
    logic [DATA_W-1:0]             out_vj;
    logic [DATA_W-1:0]             out_imm;

    logic [CDB_PORTS-1:0]          cdb_valid;
    logic [CDB_PORTS*ROB_ID_W-1:0] cdb_tag;
    logic [CDB_PORTS*DATA_W-1:0]   cdb_data;

    modport master (
        output disp_valid, disp_op, disp_pc, disp_id, disp_qi, disp_qj,
               disp_vi, disp_vj, disp_imm, out_ready, cdb_valid, cdb_tag, cdb_data,
        input  out_valid, out_op, out_id, out_pc, out_vi, out_vj, out_imm
    );

    modport slave (
        input  disp_valid, disp_op, disp_pc, disp_id, disp_qi, disp_qj,
               disp_vi, disp_vj, disp_imm, out_ready, cdb_valid, cdb_tag, cdb_data,
        output out_valid, out_op, out_id, out_pc, out_vi, out_vj, out_imm
    );
endinterface

// File: rtl/param_rsrv_station_rs_pick_oldest.sv
// Picks one ready entry: the one no other ready entry is older than.
// Latency: combinational.
// Backpressure: none; caller decides when the grant is consumed.
module rs_pick_oldest
    import param_rsrv_station_pkg::*;
#(
    parameter int N = DEF_RS_DEPTH
) (
    input  logic [N-1:0]        ready,
    input  logic [N-1:0][N-1:0] age,     // age[a][b]=1: entry a is older than entry b
    output logic [N-1:0]        grant,
    output logic                any_vld
);

    // An entry wins when no other ready entry is older than it.
    always_comb begin
        grant = '0;
        for (int i = 0; i < N; i++) begin
            grant[i] = ready[i];
            for (int j = 0; j < N; j++) begin
                if (j != i && ready[j] && age[j][i]) begin
                    grant[i] = 1'b0;
                end
            end
        end
        any_vld = |ready;
    end

endmodule

// File: rtl/param_rsrv_station.sv
// Reservation station: holds dispatched ops, snoops CDB for operands, issues one ready op per cycle.
// Latency: ready-at-dispatch op issues 2 edges after dispatch; a CDB wakeup issues on the broadcast edge.
// Backpressure: out_* held while out_valid && !out_ready; dispatch dropped when rs_full. Build option RS_AGE_SELECT_EN picks oldest instead of lowest index.
module param_rsrv_station
    import param_rsrv_station_pkg::*;
#(
    parameter int RS_DEPTH  = DEF_RS_DEPTH,
    parameter int CDB_PORTS = DEF_CDB_PORTS,
    parameter int ROB_ID_W  = DEF_ROB_ID_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int OPTYPE_W  = DEF_OPTYPE_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rdy,
    input  logic                      rollback,
    param_rsrv_station_if.slave       bus,
    output logic                      rs_full,
    output logic [$clog2(RS_DEPTH):0] rs_count
);

    localparam int CNT_W = $clog2(RS_DEPTH) + 1;

    typedef logic [ROB_ID_W-1:0] tag_t;
    typedef logic [DATA_W-1:0]   data_t;
    typedef logic [OPTYPE_W-1:0] op_t;

    typedef struct packed { tag_t q; data_t v; } opnd_t;
    typedef struct packed {
        op_t   op;
        data_t pc;
        tag_t  id;
        opnd_t src_i;
        opnd_t src_j;
        data_t imm;
    } ent_t;
    typedef struct packed {
        op_t   op;
        tag_t  id;
        data_t pc;
        data_t vi;
        data_t vj;
        data_t imm;
    } out_t;

    logic [RS_DEPTH-1:0]               busy_q, busy_d;
    logic [RS_DEPTH-1:0]               ready, grant, free_oh;
    logic [RS_DEPTH-1:0][RS_DEPTH-1:0] age_sel;
    logic                              pick_any, disp_fire;
    ent_t                              ent_q [RS_DEPTH];
    ent_t                              ent_d [RS_DEPTH];
    ent_t                              ent_w [RS_DEPTH];
    ent_t                              disp_ent, sel_ent;
    out_t                              out_q, out_d;
    logic                              out_valid_q, out_valid_d;

    // Replace a waiting operand with CDB data; lowest matching port wins, tag zero never matches.
    function automatic opnd_t snoop(input opnd_t o,
                                    input logic [CDB_PORTS-1:0]          cv,
                                    input logic [CDB_PORTS*ROB_ID_W-1:0] ct,
                                    input logic [CDB_PORTS*DATA_W-1:0]   cd);
        opnd_t r;
        logic  hit;
        r   = o;
        hit = 1'b0;
        for (int p = 0; p < CDB_PORTS; p++) begin
            if (!hit && cv[p] && o.q != tag_t'(REG_ZERO) && ct[p*ROB_ID_W +: ROB_ID_W] == o.q) begin
                r.q = tag_t'(REG_ZERO);
                r.v = cd[p*DATA_W +: DATA_W];
                hit = 1'b1;
            end
        end
        return r;
    endfunction

    assign disp_fire = bus.disp_valid && !rs_full;

    // Occupancy comes from registered busy bits only, so a slot freed this edge is not reused until next.
    always_comb begin
        rs_count = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            rs_count = rs_count + CNT_W'(busy_q[i]);
        end
        rs_full = &busy_q;
    end

    // Lowest-index free slot as a one-hot.
    always_comb begin
        logic found;
        found   = 1'b0;
        free_oh = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (!busy_q[i] && !found) begin
                free_oh[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    // Entry view with this cycle's CDB applied; an entry woken now may issue on this same edge.
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            ent_w[i] = ent_q[i];
            if (rdy && busy_q[i]) begin
                ent_w[i].src_i = snoop(ent_q[i].src_i, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
                ent_w[i].src_j = snoop(ent_q[i].src_j, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
            end
            ready[i] = busy_q[i] && ent_w[i].src_i.q == tag_t'(REG_ZERO)
                                 && ent_w[i].src_j.q == tag_t'(REG_ZERO);
        end
    end

    // Incoming op with same-cycle CDB bypass on both sources.
    always_comb begin
        disp_ent.op    = bus.disp_op;
        disp_ent.pc    = bus.disp_pc;
        disp_ent.id    = bus.disp_id;
        disp_ent.imm   = bus.disp_imm;
        disp_ent.src_i = snoop('{q: bus.disp_qi, v: bus.disp_vi}, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
        disp_ent.src_j = snoop('{q: bus.disp_qj, v: bus.disp_vj}, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    end

`ifdef RS_AGE_SELECT_EN
    logic [RS_DEPTH-1:0][RS_DEPTH-1:0] age_q, age_d;

    // A newly written slot becomes younger than every other slot.
    always_comb begin
        age_d = age_q;
        if (rollback) begin
            age_d = '0;
        end else if (rdy && disp_fire) begin
            for (int k = 0; k < RS_DEPTH; k++) begin
                if (free_oh[k]) begin
                    for (int j = 0; j < RS_DEPTH; j++) begin
                        age_d[k][j] = 1'b0;
                        age_d[j][k] = (j != k);
                    end
                end
            end
        end
    end

    // Age matrix register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

    assign age_sel = age_q;
`else
    // Fixed ordering: lower index counts as older, so the picker degenerates to a priority encoder.
    for (genvar r = 0; r < RS_DEPTH; r++) begin : g_row
        for (genvar c = 0; c < RS_DEPTH; c++) begin : g_col
            assign age_sel[r][c] = (r < c);
        end
    end
`endif

    rs_pick_oldest #(.N(RS_DEPTH)) u_pick (
        .ready   (ready),
        .age     (age_sel),
        .grant   (grant),
        .any_vld (pick_any)
    );

    // Mux out the granted entry (grant is one-hot).
    always_comb begin
        sel_ent = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (grant[i]) begin
                sel_ent = ent_w[i];
            end
        end
    end

    // Next state: rollback beats everything, rdy low freezes, otherwise wake, issue and dispatch.
    always_comb begin
        busy_d      = busy_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        for (int i = 0; i < RS_DEPTH; i++) begin
            ent_d[i] = ent_q[i];
        end
        if (rollback) begin
            busy_d      = '0;
            out_valid_d = 1'b0;
        end else if (rdy) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                ent_d[i] = ent_w[i];
            end
            if (!out_valid_q || bus.out_ready) begin
                out_valid_d = pick_any;
                if (pick_any) begin
                    out_d.op  = sel_ent.op;
                    out_d.id  = sel_ent.id;
                    out_d.pc  = sel_ent.pc;
                    out_d.vi  = sel_ent.src_i.v;
                    out_d.vj  = sel_ent.src_j.v;
                    out_d.imm = sel_ent.imm;
                    busy_d    = busy_d & ~grant;
                end
            end
            if (disp_fire) begin
                for (int i = 0; i < RS_DEPTH; i++) begin
                    if (free_oh[i]) begin
                        ent_d[i]  = disp_ent;
                        busy_d[i] = 1'b1;
                    end
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q      <= '0;
            out_valid_q <= 1'b0;
            out_q.op    <= op_t'(OP_NOP);
            out_q.id    <= tag_t'(REG_ZERO);
            out_q.pc    <= '0;
            out_q.vi    <= '0;
            out_q.vj    <= '0;
            out_q.imm   <= '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            for (int i = 0; i < RS_DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_op    = out_q.op;
    assign bus.out_id    = out_q.id;
    assign bus.out_pc    = out_q.pc;
    assign bus.out_vi    = out_q.vi;
    assign bus.out_vj    = out_q.vj;
    assign bus.out_imm   = out_q.imm;

endmodule

// File: tb/tb_param_rsrv_station.sv
// Bench for param_rsrv_station: slot/sequence-number model plus directed scenarios.
// Latency: n/a.
// Backpressure: exercises out_ready stalls, full RS, rdy low and rollback.
module tb_param_rsrv_station;

    localparam int DEPTH = 16;
    localparam int PORTS = 2;
    localparam int TW    = 5;
    localparam int DW    = 32;
    localparam int OW    = 6;

    logic       clk = 1'b0;
    logic       rst_n, rdy, rollback;
    logic       rs_full;
    logic [4:0] rs_count;

    always #5 clk = ~clk;

    param_rsrv_station_if #(.CDB_PORTS(PORTS), .ROB_ID_W(TW), .DATA_W(DW), .OPTYPE_W(OW)) rsif ();

    param_rsrv_station #(
        .RS_DEPTH(DEPTH), .CDB_PORTS(PORTS), .ROB_ID_W(TW), .DATA_W(DW), .OPTYPE_W(OW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rdy      (rdy),
        .rollback (rollback),
        .bus      (rsif),
        .rs_full  (rs_full),
        .rs_count (rs_count)
    );

    int n_chk = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: slots with dispatch sequence numbers ----------------
    typedef struct packed {
        bit            busy;
        int            seq;
        logic [TW-1:0] id, qi, qj;
        logic [OW-1:0] op;
        logic [DW-1:0] pc, vi, vj, imm;
    } ment_t;

    ment_t         m [DEPTH];
    bit            m_ov;
    logic [TW-1:0] m_oid;
    logic [OW-1:0] m_oop;
    logic [DW-1:0] m_opc, m_ovi, m_ovj, m_oimm;
    int            seq_ctr;

    function automatic int cdb_port(input logic [TW-1:0] q);
        if (q == '0) return -1;
        for (int p = 0; p < PORTS; p++)
            if (rsif.cdb_valid[p] && rsif.cdb_tag[p*TW +: TW] == q) return p;
        return -1;
    endfunction

    function automatic logic [DW-1:0] cdb_val(input int p);
        return rsif.cdb_data[p*DW +: DW];
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += int'(m[i].busy);
        return c;
    endfunction

    always @(posedge clk) begin : model
        int slot, best, p;
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) m[i] = '0;
            m_ov = 1'b0; m_oid = '0; m_oop = '0; m_opc = '0; m_ovi = '0; m_ovj = '0; m_oimm = '0;
            seq_ctr = 0;
        end else if (rollback) begin
            for (int i = 0; i < DEPTH; i++) m[i].busy = 1'b0;
            m_ov = 1'b0;
        end else if (rdy) begin
            slot = -1;
            for (int i = 0; i < DEPTH; i++) if (!m[i].busy && slot < 0) slot = i;
            for (int i = 0; i < DEPTH; i++) begin
                if (m[i].busy) begin
                    p = cdb_port(m[i].qi);
                    if (p >= 0) begin m[i].qi = '0; m[i].vi = cdb_val(p); end
                    p = cdb_port(m[i].qj);
                    if (p >= 0) begin m[i].qj = '0; m[i].vj = cdb_val(p); end
                end
            end
            if (!m_ov || rsif.out_ready) begin
                best = -1;
                for (int i = 0; i < DEPTH; i++) begin
                    if (m[i].busy && m[i].qi == '0 && m[i].qj == '0) begin
`ifdef RS_AGE_SELECT_EN
                        if (best < 0 || m[i].seq < m[best].seq) best = i;
`else
                        if (best < 0) best = i;
`endif
                    end
                end
                m_ov = (best >= 0);
                if (best >= 0) begin
                    m_oid = m[best].id; m_oop = m[best].op; m_opc = m[best].pc;
                    m_ovi = m[best].vi; m_ovj = m[best].vj; m_oimm = m[best].imm;
                    m[best].busy = 1'b0;
                end
            end
            if (rsif.disp_valid && slot >= 0) begin
                m[slot].busy = 1'b1;
                m[slot].seq  = seq_ctr;
                seq_ctr++;
                m[slot].id = rsif.disp_id;  m[slot].op = rsif.disp_op;
                m[slot].pc = rsif.disp_pc;  m[slot].imm = rsif.disp_imm;
                m[slot].qi = rsif.disp_qi;  m[slot].vi = rsif.disp_vi;
                m[slot].qj = rsif.disp_qj;  m[slot].vj = rsif.disp_vj;
                p = cdb_port(rsif.disp_qi);
                if (p >= 0) begin m[slot].qi = '0; m[slot].vi = cdb_val(p); end
                p = cdb_port(rsif.disp_qj);
                if (p >= 0) begin m[slot].qj = '0; m[slot].vj = cdb_val(p); end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("rs_count", rs_count, m_count());
            chk("rs_full", rs_full, m_count() == DEPTH);
            chk("out_valid", rsif.out_valid, m_ov);
            if (m_ov) begin
                chk("out_id", rsif.out_id, m_oid);
                chk("out_op", rsif.out_op, m_oop);
                chk("out_pc", rsif.out_pc, m_opc);
                chk("out_vi", rsif.out_vi, m_ovi);
                chk("out_vj", rsif.out_vj, m_ovj);
                chk("out_imm", rsif.out_imm, m_oimm);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic disp(input logic [4:0] id, input logic [4:0] qi, input logic [4:0] qj,
                        input logic [31:0] vi, input logic [31:0] vj);
        rsif.disp_valid = 1'b1;
        rsif.disp_id    = id;
        rsif.disp_op    = {1'b0, id};
        rsif.disp_pc    = 32'h1000 + 32'(id);
        rsif.disp_imm   = 32'hF000 + 32'(id);
        rsif.disp_qi    = qi;
        rsif.disp_qj    = qj;
        rsif.disp_vi    = vi;
        rsif.disp_vj    = vj;
    endtask

    task automatic idle();
        rsif.disp_valid = 1'b0;
        rsif.cdb_valid  = '0;
        rsif.cdb_tag    = '0;
        rsif.cdb_data   = '0;
    endtask

    initial begin
        rst_n = 1'b0; rdy = 1'b1; rollback = 1'b0;
        rsif.out_ready = 1'b1;
        disp(0, 0, 0, 0, 0);
        idle();
        tick();
        cmp_en = 1'b1;
        tick();
        chk("rst_count", rs_count, 0);
        chk("rst_full", rs_full, 0);
        chk("rst_ovalid", rsif.out_valid, 0);
        chk("rst_oid", rsif.out_id, 0);
        rst_n = 1'b1;

        // Ready-at-dispatch: stored at edge 1, issued at edge 2.
        disp(3, 0, 0, 32'h11, 32'h22); tick(); idle();
        chk("d3_cnt1", rs_count, 1);
        chk("d3_ov0", rsif.out_valid, 0);
        tick();
        chk("d3_ov1", rsif.out_valid, 1);
        chk("d3_id", rsif.out_id, 3);
        chk("d3_vi", rsif.out_vi, 32'h11);
        chk("d3_cnt0", rs_count, 0);
        tick();
        chk("d3_drop", rsif.out_valid, 0);

        // Wakeup via CDB port 1.
        disp(4, 7, 0, 0, 32'h44); tick(); idle(); tick();
        chk("w4_wait_cnt", rs_count, 1);
        chk("w4_wait_ov", rsif.out_valid, 0);
        rsif.cdb_valid = 2'b10; rsif.cdb_tag = {5'd7, 5'd0}; rsif.cdb_data = {32'h55, 32'h0};
        tick(); idle();
        chk("w4_ov", rsif.out_valid, 1);
        chk("w4_id", rsif.out_id, 4);
        chk("w4_vi", rsif.out_vi, 32'h55);
        chk("w4_vj", rsif.out_vj, 32'h44);
        tick();

        // Same tag on both ports: port 0 wins for both sources.
        disp(6, 8, 8, 0, 0); tick(); idle();
        rsif.cdb_valid = 2'b11; rsif.cdb_tag = {5'd8, 5'd8}; rsif.cdb_data = {32'hBB, 32'hAA};
        tick(); idle();
        chk("dup_id", rsif.out_id, 6);
        chk("dup_vi", rsif.out_vi, 32'hAA);
        chk("dup_vj", rsif.out_vj, 32'hAA);
        tick();

        // Dispatch-time bypass.
        disp(5, 5, 0, 0, 32'h7);
        rsif.cdb_valid = 2'b01; rsif.cdb_tag = {5'd0, 5'd5}; rsif.cdb_data = {32'h0, 32'hA0};
        tick(); idle();
        chk("byp_cnt", rs_count, 1);
        tick();
        chk("byp_ov", rsif.out_valid, 1);
        chk("byp_id", rsif.out_id, 5);
        chk("byp_vi", rsif.out_vi, 32'hA0);
        tick();

        // rdy low freezes everything and ignores dispatch.
        rdy = 1'b0; disp(12, 0, 0, 32'h12, 0); tick(); tick();
        chk("rdy0_cnt", rs_count, 0);
        rdy = 1'b1; tick(); idle();
        rdy = 1'b0; tick(); tick();
        chk("rdy0_hold_cnt", rs_count, 1);
        chk("rdy0_hold_ov", rsif.out_valid, 0);
        rdy = 1'b1; tick();
        chk("rdy1_id", rsif.out_id, 12);
        tick();

        // Output stall for 5 cycles.
        rsif.out_ready = 1'b0;
        disp(10, 0, 0, 32'h10, 0); tick();
        disp(11, 0, 0, 32'h11, 0); tick(); idle();
        chk("stall_ov", rsif.out_valid, 1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_id", rsif.out_id, 10);
            chk("stall_vi", rsif.out_vi, 32'h10);
            chk("stall_cnt", rs_count, 1);
        end
        rsif.out_ready = 1'b1; tick();
        chk("stall_next_id", rsif.out_id, 11);
        chk("stall_next_cnt", rs_count, 0);
        tick();
        chk("stall_end_ov", rsif.out_valid, 0);

        // Fill, drop extra dispatch, broadcast and drain in dispatch order.
        for (int k = 0; k < DEPTH; k++) begin
            disp(5'(16 + k), 9, 0, 0, 32'(k)); tick();
        end
        chk("full_flag", rs_full, 1);
        chk("full_cnt", rs_count, 16);
        disp(2, 9, 0, 0, 0); tick();
        chk("full_drop_cnt", rs_count, 16);
        disp(3, 0, 0, 0, 0);
        rsif.cdb_valid = 2'b01; rsif.cdb_tag = {5'd0, 5'd9}; rsif.cdb_data = {32'h0, 32'h99};
        tick(); idle();
        chk("drain_cnt", rs_count, 15);
        chk("drain_id0", rsif.out_id, 16);
        chk("drain_vi0", rsif.out_vi, 32'h99);
        for (int k = 1; k < DEPTH; k++) begin
            tick();
            chk("drain_id", rsif.out_id, 64'(16 + k));
        end
        tick();
        chk("drain_ov", rsif.out_valid, 0);
        chk("drain_empty", rs_count, 0);

        // Rollback with 6 busy entries and a stalled output.
        rsif.out_ready = 1'b0;
        for (int k = 0; k < 7; k++) begin
            disp(5'(1 + k), 0, 0, 32'(k), 0); tick();
        end
        idle();
        chk("rb_pre_cnt", rs_count, 6);
        chk("rb_pre_ov", rsif.out_valid, 1);
        chk("rb_pre_id", rsif.out_id, 1);
        rollback = 1'b1; disp(9, 0, 0, 0, 0); tick(); idle(); rollback = 1'b0;
        chk("rb_cnt", rs_count, 0);
        chk("rb_ov", rsif.out_valid, 0);
        tick();
        chk("rb_after_cnt", rs_count, 0);

        // Reset in the middle of activity.
        disp(13, 0, 0, 32'h1234, 0); tick();
        disp(14, 0, 0, 32'h14, 0); tick(); idle();
        chk("mr_pre_ov", rsif.out_valid, 1);
        chk("mr_pre_id", rsif.out_id, 13);
        rst_n = 1'b0; tick();
        chk("mr_cnt", rs_count, 0);
        chk("mr_full", rs_full, 0);
        chk("mr_ov", rsif.out_valid, 0);
        chk("mr_id", rsif.out_id, 0);
        chk("mr_op", rsif.out_op, 0);
        chk("mr_pc", rsif.out_pc, 0);
        chk("mr_vi", rsif.out_vi, 0);
        chk("mr_vj", rsif.out_vj, 0);
        chk("mr_imm", rsif.out_imm, 0);
        rst_n = 1'b1; rsif.out_ready = 1'b1; tick();
        chk("mr_after_cnt", rs_count, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
